// File: rtl/mesh_pkg.sv
// Shared port indices, destport bit positions and FSM encoding for the mesh
// output-port selection stage.
package mesh_pkg;

  localparam int unsigned P = 5;

  localparam logic [2:0] LOCAL = 3'd0;
  localparam logic [2:0] EAST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] WEST  = 3'd3;
  localparam logic [2:0] SOUTH = 3'd4;

  localparam int unsigned X_B = 3;
  localparam int unsigned Y_B = 2;
  localparam int unsigned A_B = 1;
  localparam int unsigned B_B = 0;

  typedef logic [P-1:0] port_oh_t;

  localparam port_oh_t OH_LOCAL = 5'b00001;
  localparam port_oh_t OH_EAST  = 5'b00010;
  localparam port_oh_t OH_NORTH = 5'b00100;
  localparam port_oh_t OH_WEST  = 5'b01000;
  localparam port_oh_t OH_SOUTH = 5'b10000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/mesh_credit_counter.sv
// Downstream credit counter for one output port: loads CRED_MAX on reset,
// saturates at CRED_MAX and flags an overflowing credit return.
module mesh_credit_counter #(
  parameter int unsigned CRED_MAX = 4,
  parameter int unsigned CRDw     = $clog2(CRED_MAX + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [CRDw-1:0] cnt,
  output logic            nz,
  output logic            ovf
);

  localparam logic [CRDw-1:0] MAX = CRDw'(CRED_MAX);

  logic [CRDw-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == MAX) ovf   = 1'b1;
      else              cnt_d = cnt_q + CRDw'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CRDw'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= MAX;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign nz  = (cnt_q != '0);

endmodule

// File: rtl/mesh_adaptive_port_select.sv
// Resolves the {x,y,a,b} destport of each head flit to one output port, picking
// the port with more credits when two are legal, and locks it until the tail.
module mesh_adaptive_port_select
  import mesh_pkg::*;
#(
  parameter int unsigned NX       = 2,
  parameter int unsigned NY       = 2,
  parameter int unsigned FLITw    = 32,
  parameter int unsigned CRED_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_head,
  input  logic             in_tail,
  input  logic [FLITw-1:0] in_flit,
  input  logic [3:0]       destport,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_port,
  output logic [FLITw-1:0] out_flit,
  input  logic [3:0]       credit_in,
  output logic             err
);

  localparam int unsigned CRDw = $clog2(CRED_MAX + 1);

  // Mesh dimensions do not affect this stage; degenerate sizes are unsupported.
  if (NX < 1 || NY < 1) begin : g_mesh_size_invalid
  end

  state_e   state_q, state_d;
  port_oh_t lock_q, lock_d;
  logic     err_q, err_d;

  logic [CRDw-1:0] cred [4];
  logic [3:0]      cred_nz;
  logic [3:0]      cred_ovf;
  logic [3:0]      cred_dec;

  port_oh_t        x_oh, y_oh, route_oh, sel_oh;
  logic [CRDw-1:0] x_cred, y_cred;
  logic            avail, idle_drop, xfer;

  // Credit vectors are ordered E,N,W,S, i.e. one-hot port bits [4:1].
  assign x_oh   = destport[X_B] ? OH_EAST  : OH_WEST;
  assign x_cred = destport[X_B] ? cred[0]  : cred[2];
  assign y_oh   = destport[Y_B] ? OH_NORTH : OH_SOUTH;
  assign y_cred = destport[Y_B] ? cred[1]  : cred[3];

  always_comb begin
    route_oh = OH_LOCAL;
    unique case ({destport[A_B], destport[B_B]})
      2'b11:   route_oh = (y_cred > x_cred) ? y_oh : x_oh;
      2'b10:   route_oh = x_oh;
      2'b01:   route_oh = y_oh;
      default: route_oh = OH_LOCAL;
    endcase
  end

  assign sel_oh    = (state_q == ST_LOCKED) ? lock_q : route_oh;
  assign avail     = sel_oh[LOCAL] | (|(sel_oh[SOUTH:EAST] & cred_nz));
  assign idle_drop = (state_q == ST_IDLE) & in_valid & ~in_head;

  assign out_valid = reset & in_valid & avail & ~idle_drop;
  assign in_ready  = reset & (idle_drop | (out_ready & avail));
  assign out_port  = reset ? sel_oh : '0;
  assign out_flit  = in_flit;
  assign err       = err_q;

  assign xfer     = out_valid & out_ready;
  assign cred_dec = xfer ? sel_oh[SOUTH:EAST] : '0;

  for (genvar i = 0; i < 4; i++) begin : g_cred
    mesh_credit_counter #(
      .CRED_MAX (CRED_MAX),
      .CRDw     (CRDw)
    ) u_cred (
      .clk   (clk),
      .reset (reset),
      .inc   (credit_in[i]),
      .dec   (cred_dec[i]),
      .cnt   (cred[i]),
      .nz    (cred_nz[i]),
      .ovf   (cred_ovf[i])
    );
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    err_d   = err_q | idle_drop | (|cred_ovf);
    unique case (state_q)
      ST_IDLE: begin
        if (xfer && in_head && !in_tail) begin
          state_d = ST_LOCKED;
          lock_d  = sel_oh;
        end
      end
      ST_LOCKED: begin
        if (xfer && in_tail) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mesh_adaptive_port_select.sv
// Directed bench for mesh_adaptive_port_select: routing choice, packet locking,
// credit gating/saturation, error flag and asynchronous reset.
module tb_mesh_adaptive_port_select;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_head, in_tail;
  logic [31:0] in_flit, out_flit;
  logic [3:0]  destport, credit_in;
  logic        out_valid, out_ready, err;
  logic [4:0]  out_port;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mesh_adaptive_port_select #(
    .NX       (2),
    .NY       (2),
    .FLITw    (32),
    .CRED_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_head   (in_head),
    .in_tail   (in_tail),
    .in_flit   (in_flit),
    .destport  (destport),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_port  (out_port),
    .out_flit  (out_flit),
    .credit_in (credit_in),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0;
  endtask

  task automatic pkt1(input logic [3:0] dp);
    destport = dp; in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1;
    tick();
    clear_in();
  endtask

  task automatic cred_pulse(input logic [3:0] m);
    credit_in = m;
    tick();
    credit_in = '0;
  endtask

  task automatic chk_cred(input string tag, input int unsigned e, input int unsigned n,
                          input int unsigned w, input int unsigned s);
    chk({tag, "_credE"}, 32'(dut.cred[0]), e);
    chk({tag, "_credN"}, 32'(dut.cred[1]), n);
    chk({tag, "_credW"}, 32'(dut.cred[2]), w);
    chk({tag, "_credS"}, 32'(dut.cred[3]), s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; out_ready = 1'b1; credit_in = '0; in_flit = 32'h0;
    destport = 4'b0000; in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready), 0);
    chk("rst_out_port",  32'(out_port), 0);
    clear_in();
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_err", 32'(err), 0);
    chk_cred("rst", 4, 4, 4, 4);

    // T1: x=1,a=1 -> EAST, zero latency
    destport = 4'b1010; in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1;
    in_flit = 32'hA5A5_0001;
    #1;
    chk("t1_port",     32'(out_port), 32'b00010);
    chk("t1_valid",    32'(out_valid), 1);
    chk("t1_ready",    32'(in_ready), 1);
    chk("t1_flit",     out_flit, 32'hA5A5_0001);
    tick();
    clear_in();
    chk("t1_credE", 32'(dut.cred[0]), 3);

    // T2: W=1, N=3 -> NORTH; then W=N=2 -> WEST (tie goes to X)
    pkt1(4'b0010); pkt1(4'b0010); pkt1(4'b0010);
    pkt1(4'b0101);
    chk_cred("t2a", 3, 3, 1, 4);
    destport = 4'b0111; in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1;
    #1;
    chk("t2_north", 32'(out_port), 32'b00100);
    tick();
    clear_in();
    cred_pulse(4'b0100);
    chk_cred("t2b", 3, 2, 2, 4);
    destport = 4'b0111; in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1;
    #1;
    chk("t2_tie_west", 32'(out_port), 32'b01000);
    tick();
    clear_in();
    chk_cred("t2c", 3, 2, 1, 4);

    // T3: 4-flit packet locked to EAST while NORTH gains more credit
    destport = 4'b1010; in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b0;
    #1;
    chk("t3_head_port", 32'(out_port), 32'b00010);
    tick();
    clear_in();
    cred_pulse(4'b0010); cred_pulse(4'b0010); cred_pulse(4'b0001);
    chk_cred("t3a", 3, 4, 1, 4);
    destport = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_head = 1'b0; in_tail = (i == 2);
      #1;
      chk($sformatf("t3_body%0d_port", i), 32'(out_port), 32'b00010);
      chk($sformatf("t3_body%0d_valid", i), 32'(out_valid), 1);
      tick();
    end
    clear_in();
    chk("t3_credE", 32'(dut.cred[0]), 0);
    chk("t3_err", 32'(err), 0);
    destport = 4'b0000; in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1;
    #1;
    chk("t3_idle_local_port",  32'(out_port), 32'b00001);
    chk("t3_idle_local_valid", 32'(out_valid), 1);
    tick();
    clear_in();

    // T4: SOUTH out of credit stalls the head until a credit returns
    pkt1(4'b0001); pkt1(4'b0001); pkt1(4'b0001); pkt1(4'b0001);
    chk_cred("t4a", 0, 4, 1, 0);
    destport = 4'b0001; in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1;
    #1;
    chk("t4_stall_valid", 32'(out_valid), 0);
    chk("t4_stall_ready", 32'(in_ready), 0);
    credit_in = 4'b1000;
    #1;
    chk("t4_pulse_valid", 32'(out_valid), 0);
    tick();
    credit_in = '0;
    chk("t4_go_valid", 32'(out_valid), 1);
    chk("t4_go_ready", 32'(in_ready), 1);
    chk("t4_go_port",  32'(out_port), 32'b10000);
    tick();
    clear_in();
    chk("t4_credS", 32'(dut.cred[3]), 0);

    // T5: simultaneous return+use, then overflow at CRED_MAX
    cred_pulse(4'b0001);
    destport = 4'b1010; in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b1;
    credit_in = 4'b0001;
    #1;
    chk("t5_both_valid", 32'(out_valid), 1);
    tick();
    clear_in();
    credit_in = '0;
    chk("t5_both_credE", 32'(dut.cred[0]), 1);
    cred_pulse(4'b0001); cred_pulse(4'b0001); cred_pulse(4'b0001);
    chk("t5_full_credE", 32'(dut.cred[0]), 4);
    chk("t5_full_err",   32'(err), 0);
    cred_pulse(4'b0001);
    chk("t5_ovf_credE", 32'(dut.cred[0]), 4);
    chk("t5_ovf_err",   32'(err), 1);

    // T6: reset while LOCKED, then a body flit in IDLE is dropped
    destport = 4'b0000; in_valid = 1'b1; in_head = 1'b1; in_tail = 1'b0;
    tick();
    in_head = 1'b0;
    #1;
    chk("t6_locked_valid", 32'(out_valid), 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_ready", 32'(in_ready), 0);
    chk("t6_rst_port",  32'(out_port), 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("t6_err_cleared", 32'(err), 0);
    chk_cred("t6", 4, 4, 4, 4);
    chk("t6_drop_ready", 32'(in_ready), 1);
    chk("t6_drop_valid", 32'(out_valid), 0);
    tick();
    clear_in();
    chk("t6_drop_err", 32'(err), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
